// File: rtl/noc_mm_job_sched.sv
`default_nettype none
// ============================================================================
// Module   : noc_mm_job_sched
// Purpose  : Queues matrix-multiply job descriptors and runs them one at a
//            time on the NoC MM engine. Optional watchdog: NOC_MM_SCHED_TIMEOUT_EN
// Revision : 1.0 - initial release
// ============================================================================
module noc_mm_job_sched #(
  parameter int MATRIXSIZE_W   = 24,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int QUEUE_DEPTH    = 4,
  parameter int JOB_ID_W       = 8,
  parameter int HALT_ON_ERROR  = 1
) (
  input  logic                           clk_pl,
  input  logic                           rstn_pl,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [JOB_ID_W-1:0]            job_id,
  input  logic [MATRIXSIZE_W-1:0]        job_m1,
  input  logic [MATRIXSIZE_W-1:0]        job_m2,
  input  logic [MATRIXSIZE_W-1:0]        job_m3,
  input  logic [AXI_ADDR_WIDTH-1:0]      job_addr_a,
  input  logic [AXI_ADDR_WIDTH-1:0]      job_addr_b,
  input  logic [AXI_ADDR_WIDTH-1:0]      job_addr_d,
  output logic                           mm_start,
  output logic [MATRIXSIZE_W-1:0]        mm_m1,
  output logic [MATRIXSIZE_W-1:0]        mm_m2,
  output logic [MATRIXSIZE_W-1:0]        mm_m3,
  output logic [AXI_ADDR_WIDTH-1:0]      mm_addr_a,
  output logic [AXI_ADDR_WIDTH-1:0]      mm_addr_b,
  output logic [AXI_ADDR_WIDTH-1:0]      mm_addr_d,
  input  logic                           mm_done,
  input  logic                           mm_error,
  output logic                           cmp_valid,
  output logic [JOB_ID_W-1:0]            cmp_id,
  output logic                           cmp_error,
  output logic                           cmp_timeout,
  output logic                           busy,
  output logic                           halted,
  input  logic                           err_clear,
  input  logic [31:0]                    timeout_cycles,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
  output logic [15:0]                    jobs_done
);

  localparam int c_PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int c_LVL_W  = c_PTR_W + 1;
  localparam int c_DESC_W = JOB_ID_W + 3 * MATRIXSIZE_W + 3 * AXI_ADDR_WIDTH;
  localparam logic [c_LVL_W-1:0] c_LVL_ONE   = c_LVL_W'(1);
  localparam logic [c_LVL_W-1:0] c_LVL_FULL  = c_LVL_W'(QUEUE_DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_RUN      = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  state_t                      r_state;
  logic [c_DESC_W-1:0]         r_mem [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]          r_wr_ptr;
  logic [c_PTR_W-1:0]          r_rd_ptr;
  logic [c_LVL_W-1:0]          r_level;
  logic                        r_done_q;
  logic [JOB_ID_W-1:0]         r_cur_id;
  logic                        r_mm_start;
  logic [MATRIXSIZE_W-1:0]     r_mm_m1, r_mm_m2, r_mm_m3;
  logic [AXI_ADDR_WIDTH-1:0]   r_mm_addr_a, r_mm_addr_b, r_mm_addr_d;
  logic                        r_cmp_valid;
  logic [JOB_ID_W-1:0]         r_cmp_id;
  logic                        r_cmp_error;
  logic [15:0]                 r_jobs_done;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_done_rise;
  logic [c_DESC_W-1:0]         w_desc_in;
  logic [JOB_ID_W-1:0]         w_head_id;
  logic [MATRIXSIZE_W-1:0]     w_head_m1, w_head_m2, w_head_m3;
  logic [AXI_ADDR_WIDTH-1:0]   w_head_a, w_head_b, w_head_d;

  assign job_ready   = (r_level < c_LVL_FULL);
  assign w_push      = job_valid && job_ready;
  assign w_pop       = (r_state == ST_IDLE) && (r_level != '0);
  assign w_done_rise = mm_done && !r_done_q;
  assign w_desc_in   = {job_id, job_m1, job_m2, job_m3, job_addr_a, job_addr_b, job_addr_d};
  assign {w_head_id, w_head_m1, w_head_m2, w_head_m3, w_head_a, w_head_b, w_head_d} = r_mem[r_rd_ptr];

  // Descriptor storage carries no reset; validity is tracked by r_level.
  always_ff @(posedge clk_pl) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_desc_in;
    end
  end

  always_ff @(posedge clk_pl or negedge rstn_pl) begin
    if (!rstn_pl) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (w_push && !w_pop) begin
        r_level <= r_level + c_LVL_ONE;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - c_LVL_ONE;
      end
    end
  end

`ifdef NOC_MM_SCHED_TIMEOUT_EN
  logic [31:0] r_wd_cnt;
  logic        r_cmp_timeout;
  logic [31:0] w_wd_next;
  assign w_wd_next   = r_wd_cnt + 32'd1;
  assign cmp_timeout = r_cmp_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^timeout_cycles;
  assign cmp_timeout      = 1'b0;
`endif

  always_ff @(posedge clk_pl or negedge rstn_pl) begin
    if (!rstn_pl) begin
      r_state       <= ST_IDLE;
      r_done_q      <= 1'b0;
      r_cur_id      <= '0;
      r_mm_start    <= 1'b0;
      r_mm_m1       <= '0;
      r_mm_m2       <= '0;
      r_mm_m3       <= '0;
      r_mm_addr_a   <= '0;
      r_mm_addr_b   <= '0;
      r_mm_addr_d   <= '0;
      r_cmp_valid   <= 1'b0;
      r_cmp_id      <= '0;
      r_cmp_error   <= 1'b0;
      r_jobs_done   <= 16'd0;
`ifdef NOC_MM_SCHED_TIMEOUT_EN
      r_wd_cnt      <= 32'd0;
      r_cmp_timeout <= 1'b0;
`endif
    end else begin
      r_mm_start  <= 1'b0;
      r_cmp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_level != '0) begin
            r_cur_id    <= w_head_id;
            r_mm_m1     <= w_head_m1;
            r_mm_m2     <= w_head_m2;
            r_mm_m3     <= w_head_m3;
            r_mm_addr_a <= w_head_a;
            r_mm_addr_b <= w_head_b;
            r_mm_addr_d <= w_head_d;
            r_mm_start  <= 1'b1;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // A done level left over from the previous job must not count as an edge.
          r_done_q <= mm_done;
`ifdef NOC_MM_SCHED_TIMEOUT_EN
          r_wd_cnt <= 32'd0;
`endif
          r_state  <= ST_RUN;
        end
        ST_RUN: begin
          r_done_q <= mm_done;
          if (w_done_rise) begin
            r_cmp_valid   <= 1'b1;
            r_cmp_id      <= r_cur_id;
            r_cmp_error   <= mm_error;
            r_jobs_done   <= r_jobs_done + 16'd1;
`ifdef NOC_MM_SCHED_TIMEOUT_EN
            r_cmp_timeout <= 1'b0;
`endif
            r_state       <= ST_COMPLETE;
          end
`ifdef NOC_MM_SCHED_TIMEOUT_EN
          else if ((timeout_cycles != 32'd0) && (w_wd_next == timeout_cycles)) begin
            r_cmp_valid   <= 1'b1;
            r_cmp_id      <= r_cur_id;
            r_cmp_error   <= 1'b1;
            r_cmp_timeout <= 1'b1;
            r_jobs_done   <= r_jobs_done + 16'd1;
            r_state       <= ST_COMPLETE;
          end else begin
            r_wd_cnt <= w_wd_next;
          end
`endif
        end
        ST_COMPLETE: begin
          if (r_cmp_error && (HALT_ON_ERROR != 0)) begin
            r_state <= ST_HALT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          if (err_clear) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mm_start    = r_mm_start;
  assign mm_m1       = r_mm_m1;
  assign mm_m2       = r_mm_m2;
  assign mm_m3       = r_mm_m3;
  assign mm_addr_a   = r_mm_addr_a;
  assign mm_addr_b   = r_mm_addr_b;
  assign mm_addr_d   = r_mm_addr_d;
  assign cmp_valid   = r_cmp_valid;
  assign cmp_id      = r_cmp_id;
  assign cmp_error   = r_cmp_error;
  assign busy        = (r_state != ST_IDLE) || (r_level != '0);
  assign halted      = (r_state == ST_HALT);
  assign queue_level = r_level;
  assign jobs_done   = r_jobs_done;

endmodule
`default_nettype wire
